regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rd_port.sv | 33 +++
 rtl/regfile_mp.sv | 85 ++++++++
 tb/tb_regfile_mp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N_RD   = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: address mux, hard-wired zero register and CLEAR masking.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the addressed register is forwarded.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              run,
`ifdef REGFILE_BYPASS_EN
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = regs[addr];
    if (!run || addr == '0) begin
      data = '0;
    end
`ifdef REGFILE_BYPASS_EN
    // wr_fire already excludes address 0, so only a real write is forwarded
    if (wr_fire && wr_addr == addr) begin
      data = wr_data;
    end
`endif
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file that sweeps itself to zero after every reset.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding in the same cycle).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_RD   = DEF_N_RD
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_RD*ADDR_W-1:0] Rd_Addr_ID,
  output logic [N_RD*DATA_W-1:0] Rd_Data_ID,
  input  logic                   Wr_En_WB,
  input  logic [ADDR_W-1:0]      Wr_Addr_WB,
  input  logic [DATA_W-1:0]      Wr_Data_WB,
  output logic                   Ready,
  output logic                   Wr_Drop
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   regs [2**ADDR_W];
  logic                run;
  logic                wr_req;
  logic                wr_fire;

  assign run     = (state_q == RUN);
  assign Ready   = run;
  assign wr_req  = Wr_En_WB && (Wr_Addr_WB != '0);
  assign wr_fire = wr_req && run && !Reset;
  assign Wr_Drop = wr_req && (!run || Reset);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= CLEAR;
      idx_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Index saturates at the last register so CLEAR is left exactly once
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == CLEAR) begin
      if (idx_q == LAST_IDX) begin
        state_d = RUN;
      end else begin
        idx_d = idx_q + ADDR_W'(1);
      end
    end
  end

  // Storage carries no reset; the sweep zeroes it instead
  always_ff @(posedge Clk) begin
    if (!Reset && state_q == CLEAR) begin
      regs[idx_q] <= '0;
    end else if (wr_fire) begin
      regs[Wr_Addr_WB] <= Wr_Data_WB;
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .addr    (Rd_Addr_ID[p*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .run     (run),
`ifdef REGFILE_BYPASS_EN
      .wr_fire (wr_fire),
      .wr_addr (Wr_Addr_WB),
      .wr_data (Wr_Data_WB),
`endif
      .data    (Rd_Data_ID[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int W_READY = 10;
  localparam int W_DROP  = 11;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic [NR*AW-1:0] Rd_Addr_ID = '0;
  logic [NR*DW-1:0] Rd_Data_ID;
  logic           Wr_En_WB = 1'b0;
  logic [AW-1:0]  Wr_Addr_WB = '0;
  logic [DW-1:0]  Wr_Data_WB = '0;
  logic           Ready;
  logic           Wr_Drop;

  typedef struct {
    int          cyc;
    int          what;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sbq[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  regfile_mp dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Rd_Addr_ID (Rd_Addr_ID),
    .Rd_Data_ID (Rd_Data_ID),
    .Wr_En_WB   (Wr_En_WB),
    .Wr_Addr_WB (Wr_Addr_WB),
    .Wr_Data_WB (Wr_Data_WB),
    .Ready      (Ready),
    .Wr_Drop    (Wr_Drop)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged with the current cycle
  always @(negedge Clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      item_t it;
      logic [31:0] act;
      it = sbq.pop_front();
      case (it.what)
        0:       act = Rd_Data_ID[0 +: DW];
        1:       act = Rd_Data_ID[DW +: DW];
        W_READY: act = {31'd0, Ready};
        default: act = {31'd0, Wr_Drop};
      endcase
      checks = checks + 1;
      if (it.cyc != cyc || act !== it.exp) begin
        errors = errors + 1;
        $display("FAIL %s (cycle %0d): got %h, expected %h", it.name, cyc, act, it.exp);
      end
    end
  end

  task automatic step(input logic rst, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    @(posedge Clk);
    #1;
    Reset      = rst;
    Rd_Addr_ID = {a1, a0};
    Wr_En_WB   = we;
    Wr_Addr_WB = wa;
    Wr_Data_WB = wd;
  endtask

  task automatic expect_val(input int what, input logic [31:0] v, input string name);
    item_t it;
    it.cyc  = cyc;
    it.what = what;
    it.exp  = v;
    it.name = name;
    sbq.push_back(it);
  endtask

  task automatic expect_rd(input logic [31:0] v0, input logic [31:0] v1, input string name);
    expect_val(0, v0, {name, "_p0"});
    expect_val(1, v1, {name, "_p1"});
  endtask

  // Release from reset and run the sweep, checking Ready timing and read masking
  task automatic sweep(input int n, input int wr_k, input logic [AW-1:0] ra0,
                       input logic [AW-1:0] ra1, input string name);
    for (int k = 1; k <= n; k++) begin
      if (k == wr_k) step(1'b0, ra0, ra1, 1'b1, 5'd3, 32'hCAFE_0003);
      else           step(1'b0, ra0, ra1, 1'b0, 5'd0, 32'h0);
      expect_val(W_READY, (k >= 31) ? 32'd1 : 32'd0, {name, "_ready"});
      expect_rd(32'h0, 32'h0, {name, "_rd"});
      if (k == wr_k) expect_val(W_DROP, 32'd1, {name, "_drop"});
    end
  endtask

  logic [31:0] byp_exp;

  initial begin
    // Reset values
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd7, 5'd31, 1'b1, (i == 2) ? 5'd0 : 5'd3, 32'h5555_5555);
      expect_val(W_READY, 32'd0, "rst_ready");
      expect_rd(32'h0, 32'h0, "rst_rd");
      expect_val(W_DROP, (i == 2) ? 32'd0 : 32'd1, "rst_drop");
    end

    // Release (cycle 0 of sweep), then 32 cycles with a refused write to r3 at cycle 10
    step(1'b0, 5'd3, 5'd1, 1'b0, 5'd0, 32'h0);
    expect_val(W_READY, 32'd0, "rel_ready");
    sweep(32, 10, 5'd3, 5'd30, "sweep1");

    step(1'b0, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0);
    expect_rd(32'h0, 32'h0, "r3_after_drop");

    // Write r7, read back on both ports the next cycle
    step(1'b0, 5'd1, 5'd2, 1'b1, 5'd7, 32'hDEAD_BEEF);
    expect_val(W_DROP, 32'd0, "w7_drop");
    step(1'b0, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0);
    expect_rd(32'hDEAD_BEEF, 32'hDEAD_BEEF, "r7_read");

    // Write to r0 is discarded silently
    step(1'b0, 5'd7, 5'd0, 1'b1, 5'd0, 32'h0000_1234);
    expect_val(W_DROP, 32'd0, "w0_drop");
    expect_rd(32'hDEAD_BEEF, 32'h0, "w0_same");
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    expect_rd(32'h0, 32'h0, "r0_read");

    // Same-cycle write/read of r9
`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'hA5A5_A5A5;
`else
    byp_exp = 32'h0;
`endif
    step(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 32'hA5A5_A5A5);
    expect_rd(byp_exp, byp_exp, "r9_same");
    step(1'b0, 5'd9, 5'd7, 1'b0, 5'd0, 32'h0);
    expect_rd(32'hA5A5_A5A5, 32'hDEAD_BEEF, "r9_next");

    // Preload all registers to ones
    for (int a = 1; a < 32; a++) begin
      step(1'b0, 5'd0, 5'd0, 1'b1, 5'(a), 32'hFFFF_FFFF);
      if (a == 1 || a == 31) expect_val(W_DROP, 32'd0, "pre_drop");
    end
    step(1'b0, 5'd5, 5'd31, 1'b0, 5'd0, 32'h0);
    expect_rd(32'hFFFF_FFFF, 32'hFFFF_FFFF, "pre_read");

    // Reset, sweep to cycle 15 (r31/r20 still hold ones but must read 0), reset again
    step(1'b1, 5'd31, 5'd20, 1'b0, 5'd0, 32'h0);
    step(1'b0, 5'd31, 5'd20, 1'b0, 5'd0, 32'h0);
    expect_rd(32'h0, 32'h0, "mask_rel");
    sweep(15, 0, 5'd31, 5'd20, "sweepA");
    step(1'b1, 5'd31, 5'd20, 1'b0, 5'd0, 32'h0);
    expect_val(W_READY, 32'd0, "midrst_ready");
    step(1'b0, 5'd31, 5'd20, 1'b0, 5'd0, 32'h0);
    expect_val(W_READY, 32'd0, "rel2_ready");
    sweep(32, 0, 5'd31, 5'd20, "sweepB");

    // Every register reads zero after the sweep
    for (int a = 1; a < 32; a++) begin
      step(1'b0, 5'(a), 5'(32 - a), 1'b0, 5'd0, 32'h0);
      expect_rd(32'h0, 32'h0, "post_clear");
    end

    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    @(posedge Clk);
    @(posedge Clk);
    checks = checks + 1;
    if (sbq.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
